// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Provides the loader FSM state encoding, the bus width and a range helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package imem_loader_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_RECV  = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_t;

  // True when a word index falls inside a memory of 'depth' words.
  function automatic logic addr_in_range(input logic [WORD_SIZE-1:0] addr,
                                         input int unsigned depth);
    return addr < WORD_SIZE'(depth);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream big-endian into 32-bit words (first byte -> bits 31:24).
// Latency: word/word_full are combinational on the strobe that carries the 4th byte.
// Backpressure: none; the caller only strobes bytes it has accepted.
// Ports: clk, clear (sync, drops any partial word), byte_stb, byte_in -> word, word_full.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 byte_stb,
  input  logic [7:0]           byte_in,
  output logic [WORD_SIZE-1:0] word,
  output logic                 word_full
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (byte_stb) begin
      // Counter wraps 3 -> 0 so the next word starts clean without a clear.
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_in};
    end
  end

  // Only the first three bytes are stored; the fourth is taken straight from
  // the input so the loader can register the complete word on the same edge
  // that accepts the last byte (keeps the 4 RECV + 1 WRITE cadence).
  assign word      = {shift_q, byte_in};
  assign word_full = byte_stb && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into instruction memory via IAddrE/IInE/IWriteE,
// holding the core off (CoreHold) during the load; reports Done/Error/Checksum.
// Latency: one write per 5 cycles with a gapless stream (4 byte cycles + 1 write cycle).
// Backpressure: ByteReady is high only in RECV; the sender holds ByteIn until taken.
// Ports: PHI1/MRST; Start, BaseAddr, NumWords; ByteIn/ByteValid/ByteReady;
//        IAddrE/IInE/IWriteE to memory; CoreHold, Busy, Done, Error, Checksum status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS = 128,
  parameter int CNT_W = 16
) (
  input  logic                 PHI1,
  input  logic                 MRST,
  input  logic                 Start,
  input  logic [WORD_SIZE-1:0] BaseAddr,
  input  logic [CNT_W-1:0]     NumWords,
  input  logic [7:0]           ByteIn,
  input  logic                 ByteValid,
  output logic                 ByteReady,
  output logic [WORD_SIZE-1:0] IAddrE,
  output logic [WORD_SIZE-1:0] IInE,
  output logic                 IWriteE,
  output logic                 CoreHold,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [WORD_SIZE-1:0] Checksum
);

  ldr_state_t           state;
  logic [WORD_SIZE-1:0] base_addr;
  logic [CNT_W-1:0]     num_words;
  logic [CNT_W-1:0]     index;
  logic [CNT_W-1:0]     idx_next;
  logic [WORD_SIZE-1:0] wr_addr;
  logic                 addr_ok;
  logic                 start_acc;
  logic                 byte_stb;
  logic [WORD_SIZE-1:0] word;
  logic                 word_full;

  assign start_acc = Start && ((state == LDR_IDLE) || (state == LDR_DONE));
  assign byte_stb  = ByteValid && ByteReady;
  assign idx_next  = index + CNT_W'(1);
  // 32-bit wraparound is intentional: a huge BaseAddr must not alias back in range
  // unless the 32-bit sum really is below WORDS.
  assign wr_addr   = base_addr + WORD_SIZE'(index);
  assign addr_ok   = addr_in_range(wr_addr, WORDS);

  imem_word_packer u_packer (
    .clk       (PHI1),
    .clear     (MRST || start_acc),
    .byte_stb  (byte_stb),
    .byte_in   (ByteIn),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge PHI1) begin
    if (MRST) begin
      state     <= LDR_IDLE;
      base_addr <= '0;
      num_words <= '0;
      index     <= '0;
      ByteReady <= 1'b0;
      IAddrE    <= '0;
      IInE      <= '0;
      IWriteE   <= 1'b0;
      CoreHold  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      Checksum  <= '0;
    end else begin
      case (state)
        LDR_IDLE, LDR_DONE: begin
          if (Start) begin
            base_addr <= BaseAddr;
            num_words <= NumWords;
            index     <= '0;
            Checksum  <= '0;
            Error     <= 1'b0;
            if (NumWords == '0) begin
              // Empty load: straight to DONE, core never held.
              state     <= LDR_DONE;
              Done      <= 1'b1;
              CoreHold  <= 1'b0;
              Busy      <= 1'b0;
              ByteReady <= 1'b0;
            end else begin
              state     <= LDR_RECV;
              Done      <= 1'b0;
              CoreHold  <= 1'b1;
              Busy      <= 1'b1;
              ByteReady <= 1'b1;
            end
          end
        end

        LDR_RECV: begin
          // Write-cycle outputs are loaded here so they are already stable
          // throughout the WRITE cycle (memory samples on the falling edge).
          if (word_full) begin
            state     <= LDR_WRITE;
            ByteReady <= 1'b0;
            IAddrE    <= wr_addr;
            IInE      <= word;
            if (addr_ok) begin
              IWriteE  <= 1'b1;
              Checksum <= Checksum + word;
            end else begin
              Error    <= 1'b1;
            end
          end
        end

        LDR_WRITE: begin
          IWriteE <= 1'b0;
          // IWriteE doubles as the "this write was in range" flag.
          if (IWriteE && (idx_next != num_words)) begin
            index     <= idx_next;
            state     <= LDR_RECV;
            ByteReady <= 1'b1;
          end else begin
            if (IWriteE) begin
              index <= idx_next;
            end
            state    <= LDR_DONE;
            Done     <= 1'b1;
            CoreHold <= 1'b0;
            Busy     <= 1'b0;
          end
        end

        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule
